// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 T1-T6 ring counter and opcode decode into the 12-bit control word.
// A halted machine is encoded as the all-zero ring state, so HLT comes straight from the state register.
module controller_sequencer (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  instr_in,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        HLT
);
    typedef enum logic [5:0] {
        HALTED = 6'b000000,
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000
    } state_t;

    localparam logic [11:0] IDLE = 12'h3E3;

    state_t state, next;

    always_ff @(posedge CLK) begin
        if (CLR) state <= T1;
        else     state <= next;
    end

    // Execute words depend on the opcode only in T4-T6; fetch words are fixed.
    always_comb begin
        next = state;
        con  = IDLE;
        case (state)
            T1: begin
                con  = 12'h5E3;
                next = T2;
            end
            T2: begin
                con  = 12'hBE3;
                next = T3;
            end
            T3: begin
                con  = 12'h263;
                next = T4;
            end
            T4: begin
                con  = (instr_in <= 4'h2) ? 12'h1A3 : (instr_in == 4'hE) ? 12'h3F2 : IDLE;
                next = (instr_in == 4'hF) ? HALTED : T5;
            end
            T5: begin
                con  = (instr_in == 4'h0) ? 12'h2C3 : (instr_in <= 4'h2) ? 12'h2E1 : IDLE;
                next = T6;
            end
            T6: begin
                con  = (instr_in == 4'h1) ? 12'h3C7 : (instr_in == 4'h2) ? 12'h3CF : IDLE;
                next = T1;
            end
            HALTED: next = HALTED;
            default: next = T1;
        endcase
    end

    assign t_state = state;
    assign HLT     = (state == HALTED);

    // At most one driver on the W bus: Ep, Ei_bar low, Ea, Eu, CE_bar low.
    bus_one_driver: assert property (@(posedge CLK)
        $countones({con[10], ~con[6], con[4], con[2], ~con[8]}) <= 1);
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: directed SAP-1 sequences plus random opcodes/resets checked against
// a step-counter model with per-opcode control-word tables.
module tb_controller_sequencer;
    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [3:0]  instr_in = 4'h0;
    logic [11:0] con;
    logic [5:0]  t_state;
    logic        HLT;

    int checks = 0;
    int failures = 0;

    int   st = 0;
    logic halted = 1'b0;
    logic [11:0] fetch_tbl [3];
    logic [11:0] exec_tbl  [16][3];

    controller_sequencer dut (
        .CLK(CLK),
        .CLR(CLR),
        .instr_in(instr_in),
        .con(con),
        .t_state(t_state),
        .HLT(HLT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic c, input logic [3:0] i);
        logic [11:0] exp_con;
        CLR = c;
        instr_in = i;
        @(posedge CLK);
        if (c) begin
            st = 0;
            halted = 1'b0;
        end else if (!halted) begin
            if (st == 3 && i == 4'hF) halted = 1'b1;
            else st = (st + 1) % 6;
        end
        #1;
        exp_con = halted ? 12'h3E3 : (st < 3) ? fetch_tbl[st] : exec_tbl[i][st-3];
        chk("t_state", {6'd0, t_state}, halted ? 12'd0 : 12'(1 << st));
        chk("hlt", {11'd0, HLT}, {11'd0, halted});
        chk("con", con, exp_con);
    endtask

    task automatic run_op(input logic [3:0] op);
        for (int k = 0; k < 6; k++) cyc(1'b0, op);
    endtask

    initial begin
        fetch_tbl[0] = 12'h5E3;
        fetch_tbl[1] = 12'hBE3;
        fetch_tbl[2] = 12'h263;
        for (int o = 0; o < 16; o++)
            for (int k = 0; k < 3; k++) exec_tbl[o][k] = 12'h3E3;
        exec_tbl[0]  = '{12'h1A3, 12'h2C3, 12'h3E3};
        exec_tbl[1]  = '{12'h1A3, 12'h2E1, 12'h3C7};
        exec_tbl[2]  = '{12'h1A3, 12'h2E1, 12'h3CF};
        exec_tbl[14] = '{12'h3F2, 12'h3E3, 12'h3E3};

        cyc(1'b1, 4'h0);
        cyc(1'b1, 4'h0);
        run_op(4'h0);
        run_op(4'h1);
        run_op(4'h2);
        run_op(4'hE);
        run_op(4'h5);
        for (int k = 0; k < 4; k++) cyc(1'b0, 4'hF);
        for (int k = 0; k < 20; k++) cyc(1'b0, 4'($urandom));
        cyc(1'b1, 4'h3);
        for (int k = 0; k < 4; k++) cyc(1'b0, 4'h1);
        cyc(1'b1, 4'h1);

        // Opcode may change freely in T1-T3 and while halted; it is held through T4-T6.
        for (int n = 0; n < 3000; n++) begin
            logic c;
            logic [3:0] i;
            c = halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
            i = (halted || st <= 2) ? 4'($urandom) : instr_in;
            cyc(c, i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller-sequencer, directly downstream of the instruction register. It runs a six-state one-hot ring counter (T1–T6) and decodes the 4-bit opcode from the instruction register into the 12-bit control word that drives the program counter, MAR, RAM, IR, accumulator, adder/subtractor, B register and output register. It executes LDA, ADD, SUB, OUT and HLT. On HLT it freezes the machine until reset.

## Interface
- No parameters; all widths fixed by the SAP-1 architecture.
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  reset, synchronous and active-high; forces T1 and clears halt.
- instr_in  input  4  opcode from the instruction register; must be stable during T4–T6.
- con  output  12  control word, bit order [11:0] = Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar.
- t_state  output  6  one-hot ring state, bit0 = T1 … bit5 = T6; all-zero when halted.
- HLT  output  1  high while halted; gates the system clock enable elsewhere.

## Operation
- State register: one-hot ring T1→T2→T3→T4→T5→T6→T1, advancing one step per CLK edge.
- Idle (inactive) control word is 0x3E3: all active-low loads/enables high, all active-high signals low.
- The control word is a combinational Moore-style decode of t_state (and instr_in in T4–T6).
- Fetch cycle, identical for every opcode:
  - T1 = 0x5E3 (Ep, Lm_bar).
  - T2 = 0xBE3 (Cp).
  - T3 = 0x263 (CE_bar, Li_bar).
- Execute cycle:
  - LDA 0000: T4 0x1A3 (Ei_bar, Lm_bar); T5 0x2C3 (CE_bar, La_bar); T6 0x3E3.
  - ADD 0001: T4 0x1A3; T5 0x2E1 (CE_bar, Lb_bar); T6 0x3C7 (Eu, La_bar).
  - SUB 0010: same as ADD except T6 = 0x3CF (Su, Eu, La_bar).
  - OUT 1110: T4 0x3F2 (Ea, Lo_bar); T5 0x3E3; T6 0x3E3.
  - HLT 1111: T4 0x3E3. At the edge ending T4, set the halt flag and clear t_state to 000000.
  - Any other opcode: NOP, 0x3E3 in T4–T6, and the ring continues normally.
- Halted state:
  - t_state = 000000, con = 0x3E3, HLT = 1.
  - Holds indefinitely and ignores instr_in.
  - Only CLR exits this state.
- Never drive two bus enables (Ep, Ei_bar low, Ea, Eu, CE_bar low) in the same state. The tables above satisfy this; an assertion must check it.

## Timing
- Reset: when CLR is high at a rising edge, the next state is t_state = 000001, HLT = 0, so con = 0x5E3.
- CLR has priority over halt and over ring advance, including in the middle of an instruction (e.g. during T5 of ADD): the next cycle is T1 with no partial loads.
- Each instruction takes exactly 6 cycles; the next fetch starts in the cycle after T6.
- HLT takes 4 cycles from T1 to halted. The HLT output rises in the cycle after T4 and stays registered high.
- instr_in is read only in T4–T6. Changes during T1–T3 must not affect con.
- con updates combinationally within the cycle after a state edge. Downstream registers sample it on the next rising edge.
- No X or Z on any output after the first reset edge.

## Test plan
- Reset: assert CLR for 2 cycles, then release → t_state = 000001, con = 0x5E3, HLT = 0. Over the next 3 cycles con = 0xBE3, then 0x263, then instr_in-dependent.
- LDA: instr_in = 0000, run 6 cycles from T1 → con sequence 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2C3, 0x3E3, then back to T1.
- ADD then SUB back-to-back: instr_in = 0001 then 0010 → T6 con = 0x3C7 for ADD and 0x3CF for SUB, with T4/T5 equal to 0x1A3/0x2E1 for both.
- OUT and undefined opcode: instr_in = 1110 → T4 = 0x3F2, T5/T6 = 0x3E3. instr_in = 0101 → T4–T6 = 0x3E3 and the ring continues.
- HLT: instr_in = 1111 → after the T4 edge, HLT = 1, t_state = 000000, con = 0x3E3. Holds for 20 cycles while instr_in toggles. Pulsing CLR → T1, HLT = 0.
- Mid-instruction reset: assert CLR during T5 of ADD → next cycle t_state = 000001, con = 0x5E3. A bus-conflict assertion runs in all tests.
